// File: rtl/spm_clear_ctrl_pkg.sv
// Shared constants for the SPM bank clear sequencer: FSM encoding and reset-state selection.
package spm_clear_ctrl_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    function automatic logic [0:0] reset_state(input logic clear_on_reset);
        return clear_on_reset ? ST_CLEAR : ST_IDLE;
    endfunction

endpackage

// File: rtl/spm_clear_ctrl_counter.sv
// Clear-sweep address counter: held at zero while cleared, steps when enabled,
// and wraps to zero after the terminal value instead of at 2^width.
module spm_clear_ctrl_counter #(
    parameter int unsigned Width    = 10,
    parameter int unsigned MaxValue = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [Width-1:0] count,
    output logic             last
);

    localparam logic [Width-1:0] LastValue = Width'(MaxValue);

    logic [Width-1:0] count_r;
    logic             last_s;

    assign last_s = (count_r == LastValue);

    // Address register: zero on clear or after the last word, otherwise increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {Width{1'b0}};
        end else if (clear) begin
            count_r <= {Width{1'b0}};
        end else if (en) begin
            if (last_s) begin
                count_r <= {Width{1'b0}};
            end else begin
                count_r <= count_r + Width'(1'b1);
            end
        end
    end

    assign count = count_r;
    assign last  = last_s;

endmodule

// File: rtl/spm_clear_ctrl.sv
// Arbiter/sequencer in front of one latency-1 SRAM bank: passes external requests
// through in IDLE and takes the bank over to zero-fill every word in CLEAR.
module spm_clear_ctrl
    import spm_clear_ctrl_pkg::*;
#(
    parameter int unsigned NumWords     = 1024,
    parameter int unsigned DataWidth    = 64,
    parameter logic        ClearOnReset = 1'b0,
    parameter int unsigned AddrWidth    = $clog2(NumWords)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_req_i,
    output logic                   clear_busy_o,
    output logic                   clear_done_o,
    input  logic                   mem_req_i,
    output logic                   mem_gnt_o,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic                   mem_we_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    input  logic [DataWidth/8-1:0] mem_strb_i,
    output logic                   mem_rvalid_o,
    output logic [DataWidth-1:0]   mem_rdata_o,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [AddrWidth-1:0]   sram_addr_o,
    output logic [DataWidth-1:0]   sram_wdata_o,
    output logic [DataWidth/8-1:0] sram_be_o,
    input  logic [DataWidth-1:0]   sram_rdata_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    logic [0:0]           state_r;
    logic [0:0]           state_next_s;
    logic                 in_clear_s;
    logic                 clr_last_s;
    logic [AddrWidth-1:0] clr_addr_q;
    logic                 rvalid_r;
    logic                 done_r;

    assign in_clear_s = (state_r == ST_CLEAR);

    // Holding the counter cleared throughout IDLE guarantees every sweep starts at word 0
    spm_clear_ctrl_counter #(
        .Width    (AddrWidth),
        .MaxValue (NumWords - 1)
    ) u_clr_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clear (~in_clear_s),
        .en    (in_clear_s),
        .count (clr_addr_q),
        .last  (clr_last_s)
    );

    // Next-state logic: clear requests are only honoured from IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // SRAM port mux: clear writes own the bank in CLEAR, external port otherwise
    always_comb begin
        sram_req_o   = mem_req_i;
        sram_we_o    = mem_we_i;
        sram_addr_o  = mem_addr_i;
        sram_wdata_o = mem_wdata_i;
        sram_be_o    = mem_strb_i;
        if (in_clear_s) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = clr_addr_q;
            sram_wdata_o = {DataWidth{1'b0}};
            sram_be_o    = {StrbWidth{1'b1}};
        end else begin
            sram_req_o   = mem_req_i;
            sram_we_o    = mem_we_i;
            sram_addr_o  = mem_addr_i;
            sram_wdata_o = mem_wdata_i;
            sram_be_o    = mem_strb_i;
        end
    end

    // State, response-valid and done-pulse registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= reset_state(ClearOnReset);
            rvalid_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            rvalid_r <= mem_req_i & ~in_clear_s;
            done_r   <= in_clear_s & clr_last_s;
        end
    end

    assign mem_gnt_o    = ~in_clear_s;
    assign clear_busy_o = in_clear_s;
    assign clear_done_o = done_r;
    assign mem_rvalid_o = rvalid_r;
    assign mem_rdata_o  = sram_rdata_i;

endmodule
